load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store engine between the datapath's ALU and an external data bus. It takes the effective address (ALU result), store data (register rs2 value), access size and signedness from the datapath. It performs one handshaked bus transaction per access and returns aligned, sign- or zero-extended load data. It stalls the datapath via `busy` and flags misaligned accesses and bus timeouts instead of issuing bad transactions.

## Interface
- `TIMEOUT`, 255: max cycles `bus_req` is held without `bus_ack` before abort; 1..1023.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  access request; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `is_unsigned`  in  1  load zero-extend (funct3[2]); ignored for stores
- `address`  in  32  byte address
- `store_data`  in  32  store operand, low bits used for sub-word
- `load_data`  out  32  extended load result
- `busy`  out  1  stall request to datapath
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  valid with `done`; access not issued
- `bus_err`  out  1  valid with `done`; timeout abort
- `bus_req`  out  1  bus request, held until ack
- `bus_we`  out  1  bus write enable
- `bus_addr`  out  32  `{address[31:2], 2'b00}`
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_rdata`  in  32  read data, valid with `bus_ack`
- `bus_ack`  in  1  transaction complete

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE + `start`: latch `is_store`, `mem_size`, `is_unsigned`, `address[1:0]`, and drive bus fields.
  - If misaligned, go to DONE with `misaligned` set. Misaligned means half with `address[0]`=1, word with `address[1:0]`≠0, or `mem_size`=11.
  - Otherwise go to ACCESS and clear the timeout counter.
- ACCESS: `bus_req`=1; address, `bus_we`, `bus_be` and `bus_wdata` stay stable.
  - `bus_ack`=1: capture `bus_rdata`, then go to DONE.
  - Counter reaches `TIMEOUT` without ack: go to DONE with `bus_err`=1.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored in DONE and ACCESS.
- Byte enables and write data:
  - byte: `bus_be` = 1<<`address[1:0]`; `bus_wdata` = 4 copies of `store_data[7:0]`.
  - half: `bus_be` = 0011 if `address[1]`=0, else 1100; `bus_wdata` = 2 copies of `store_data[15:0]`.
  - word: `bus_be` = 1111; `bus_wdata` = `store_data`.
  - Loads drive the same `bus_be`.
- Load extraction: select the byte or half lane by latched `address[1:0]`, then sign-extend, or zero-extend when `is_unsigned`=1. Word loads pass through.
- `load_data` updates only on a successful load. It holds its value across stores, errors and misaligned accesses.
- `busy` = (IDLE & `start`) | ACCESS. This path is combinational from `start`. `busy` is low in DONE so the datapath advances on the `done` cycle.
- `misaligned` and `bus_err` are high only during the DONE cycle and are mutually exclusive.

## Timing
- Reset, asynchronous and active-low:
  - State goes to IDLE immediately.
  - `bus_req`, `bus_we`, `done`, `misaligned`, `bus_err` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `load_data` = 0.
  - Timeout counter = 0.
- Reset mid-ACCESS drops `bus_req` without waiting for ack; a late ack after reset is ignored in IDLE.
- All bus outputs, `done` and `load_data` are registered.
- Minimum latency, ack in the first ACCESS cycle:
  - cycle 0: `start` in IDLE.
  - cycle 1: `bus_req`=1, ack=1.
  - cycle 2: `done`=1, `load_data` valid.
  - cycle 3: IDLE, new `start` accepted.
- Back-to-back throughput is 3 cycles per access at zero wait states.
- N wait states add N cycles.
- Misaligned path: `start` at cycle 0, `done` + `misaligned` at cycle 1, no `bus_req` ever.
- Timeout: `bus_req` stays high for exactly `TIMEOUT` cycles; `done` + `bus_err` follow in the next cycle.
- Ack on the same edge the counter hits `TIMEOUT`: ack wins, completing normally with no `bus_err`.

## Test plan
- Word load, `address`=0x100, ack 1st cycle, `bus_rdata`=0xDEADBEEF -> `bus_addr`=0x100, `bus_be`=1111, `done` at cycle 2, `load_data`=0xDEADBEEF.
- Signed byte load, `address`=0x103, `bus_rdata`=0x80123456 -> `bus_be`=1000, `load_data`=0xFFFFFF80.
- Same access with `is_unsigned`=1 -> `load_data`=0x00000080.
- Half store, `address`=0x22, `store_data`=0x1234ABCD, 3 wait states -> `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_req` high 4 cycles, `done` at cycle 5.
- Word load at 0x102, then half store at 0x101 -> `done` + `misaligned` one cycle after `start`, `bus_req` never asserted, `load_data` unchanged.
- `TIMEOUT`=8, no ack -> `bus_req` high 8 cycles, then `done` + `bus_err`.
- Repeat with ack exactly on the 8th cycle -> normal completion, no error.
- Reset asserted in the 2nd ACCESS cycle -> `bus_req`=0 immediately, all outputs 0; the next `start` after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine issuing one handshaked bus access per request,
// with alignment checking, bus timeout abort and sign/zero-extended load return.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_is_store,
    input  logic [1:0]  i_mem_size,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_address,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  r_state;
    logic        r_is_store;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [9:0]  r_cnt;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_lane;
    logic [31:0] w_ext;

    assign w_misaligned = (i_mem_size == 2'b11) | ((i_mem_size == 2'b01) & i_address[0]) |
                          ((i_mem_size == 2'b10) & (|i_address[1:0]));
    assign w_be    = (i_mem_size == 2'b00) ? 4'b0001 << i_address[1:0] :
                     (i_mem_size == 2'b01) ? (i_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = (i_mem_size == 2'b00) ? {4{i_store_data[7:0]}} :
                     (i_mem_size == 2'b01) ? {2{i_store_data[15:0]}} : i_store_data;
    // Shifting the read word down by the latched lane offset puts the addressed byte/half at bit 0.
    assign w_lane  = 16'(i_bus_rdata >> {r_off, 3'b000});
    assign w_ext   = (r_size == 2'b00) ? {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]} :
                     (r_size == 2'b01) ? {{16{~r_unsigned & w_lane[15]}}, w_lane} : i_bus_rdata;
    assign w_timeout = (r_cnt == 10'(TIMEOUT - 1));
    assign o_busy    = ((r_state == IDLE) & i_start) | (r_state == ACCESS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_is_store   <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_cnt        <= 10'd0;
            o_load_data  <= 32'd0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= 32'd0;
            o_bus_be     <= 4'd0;
            o_bus_wdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_is_store  <= i_is_store;
                    r_unsigned  <= i_is_unsigned;
                    r_size      <= i_mem_size;
                    r_off       <= i_address[1:0];
                    r_cnt       <= 10'd0;
                    o_bus_addr  <= {i_address[31:2], 2'b00};
                    o_bus_be    <= w_be;
                    o_bus_wdata <= w_wdata;
                    if (w_misaligned) begin
                        r_state      <= DONE;
                        o_done       <= 1'b1;
                        o_misaligned <= 1'b1;
                    end else begin
                        r_state   <= ACCESS;
                        o_bus_req <= 1'b1;
                        o_bus_we  <= i_is_store;
                    end
                end
                ACCESS: begin
                    // An ack arriving on the final counted cycle takes priority over the abort.
                    if (i_bus_ack) begin
                        r_state   <= DONE;
                        o_bus_req <= 1'b0;
                        o_bus_we  <= 1'b0;
                        o_done    <= 1'b1;
                        if (!r_is_store) o_load_data <= w_ext;
                    end else if (w_timeout) begin
                        r_state   <= DONE;
                        o_bus_req <= 1'b0;
                        o_bus_we  <= 1'b0;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    o_done       <= 1'b0;
                    o_misaligned <= 1'b0;
                    o_bus_err    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
